adventure_game_ctrl: RTL and testbench
======================================

Name: adventure_game_ctrl

Overview:
- Parametrised successor of the team's seven-room adventure-game controller: room FSM with an integrated sword flag, plus a life counter, a move counter with timeout and edge-detected direction inputs.
- Sits at the top of the game design; the direction buttons drive it directly and its outputs drive the room LEDs and the status display.
- Generalises the original with configurable lives, respawn, move-limit timeout and a sword-retention mode.

Parameters:
- LIVES, 3, starting lives; legal range 1..2^LIFE_W-1.
- LIFE_W, 2, width of the lives counter.
- MOVE_W, 8, width of the move counter.
- MAX_MOVES, 20, accepted-move limit before timeout; legal range 1..2^MOVE_W-1.
- KEEP_SWORD, 0, 1 = sword survives a respawn; 0 = sword is cleared on respawn.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- n  in  1  north button.
- s  in  1  south button.
- e  in  1  east button.
- w  in  1  west button.
- room  out  7  one-hot location: bits 0-3 = rooms s0-s3, bit4 = den s4, bit5 = vault s5, bit6 = graveyard s6.
- sword  out  1  sword held.
- lives  out  LIFE_W  remaining lives.
- moves  out  MOVE_W  accepted moves since reset.
- die  out  1  player dead: high in DEAD and OVER.
- win  out  1  player won: high in WIN.
- game_over  out  1  high in OVER only.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high. All state is registered on the rising edge of clk.
- Reset values: room=7'b0000001, sword=0, lives=LIVES, moves=0, die=0, win=0, game_over=0, previous-direction register=4'b0000.
- Press detection: a direction is accepted in a cycle only if both hold:
  - exactly one of {n,s,e,w} is high;
  - the registered previous vector {n,s,e,w} was 4'b0000.
- Press detection, other cases: multiple bits high or a held button → no action. The previous-vector register updates every cycle.
- States: S0, S1, S2, S3, S4, WIN, DEAD, OVER.
- Exits (accepted press only; any other direction = no move, no count):
  - S0: e→S1.
  - S1: s→S2; w→S0.
  - S2: n→S1; w→S3; e→S4.
  - S3: e→S2.
- Sword: entering S3 sets sword=1 on the same edge.
- Move counting: each accepted press that changes room increments moves by 1. moves never wraps; it stops at MAX_MOVES. moves is not cleared on respawn.
- S4 (den) is a one-cycle transit state. Next cycle:
  - sword=1 → WIN;
  - sword=0 → DEAD, with lives decremented on that edge.
- WIN: terminal; win=1 and room bit5 held until reset.
- DEAD: lasts one cycle; die=1, room bit6. Next cycle:
  - lives>0 → S0, moves unchanged, sword cleared unless KEEP_SWORD=1;
  - lives==0 → OVER.
- OVER: terminal until reset; die=1, game_over=1, room bit6.
- Timeout: in S0-S3, if moves==MAX_MOVES at the clock edge, the next state is OVER regardless of input. Timeout has priority over any move. No life is deducted on timeout.
- Simultaneous events: a move that makes moves reach MAX_MOVES completes normally. The timeout fires on the following edge, unless that move entered S4; S4 resolves first.
- Buttons are ignored in S4, WIN, DEAD and OVER. moves does not change in those states.
- Reset mid-operation: all outputs return to their reset values immediately (asynchronous), including from WIN and OVER.
- Invariants, checked by assertion: room is always one-hot; win and die are never both 1.

Test Plan:
- Win path: reset; presses e, s, w, e, e (each a 1-cycle pulse separated by idle cycles) → room sequence S1, S2, S3 (sword=1), S2, S4. One cycle later win=1, room=7'b0100000, moves=5.
- Death and respawn: LIVES=3. Presses e, s, e → S4, then DEAD: die=1 for exactly 1 cycle, lives=2. Then room=7'b0000001, moves=3, die=0.
- Game over on lives: LIVES=1; e, s, e → DEAD then OVER. game_over=1, die=1, lives=0. Further presses produce no change.
- Edge detect and invalid input: hold e for 10 cycles → one move only (S1, moves=1). Press n+e together → no move. Press n in S0 → no move, moves unchanged.
- Timeout: MAX_MOVES=4; e, w, e, w → moves=4, room S0. Next edge → OVER, game_over=1, lives unchanged at 3.
- KEEP_SWORD=1: take the sword, return to S0, wait for timeout with MAX_MOVES large; verify sword is retained through a forced death-free path. Then assert reset mid-WIN → room=7'b0000001, win=0, sword=0 asynchronously.

Source files
------------

// File: rtl/adventure_game_ctrl.sv
// Seven-room adventure-game controller: room FSM with sword flag, life counter,
// saturating move counter with timeout, and edge-detected direction buttons.
module adventure_game_ctrl #(
    parameter int LIVES      = 3,
    parameter int LIFE_W     = 2,
    parameter int MOVE_W     = 8,
    parameter int MAX_MOVES  = 20,
    parameter int KEEP_SWORD = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              n,
    input  logic              s,
    input  logic              e,
    input  logic              w,
    output logic [6:0]        room,
    output logic              sword,
    output logic [LIFE_W-1:0] lives,
    output logic [MOVE_W-1:0] moves,
    output logic              die,
    output logic              win,
    output logic              game_over
);

    typedef enum logic [2:0] {S0, S1, S2, S3, S4, WIN, DEAD, OVER} state_t;

    localparam logic [LIFE_W-1:0] LIVES_INIT = LIFE_W'(LIVES);
    localparam logic [MOVE_W-1:0] MOVE_LIMIT = MOVE_W'(MAX_MOVES);

    state_t            state_q, state_d;
    logic              sword_q, sword_d;
    logic [LIFE_W-1:0] lives_q, lives_d;
    logic [MOVE_W-1:0] moves_q, moves_d;
    logic [3:0]        prev_q;
    logic [6:0]        room_q;
    logic              die_q, win_q, over_q;

    logic [3:0] dir;
    logic       press, press_n, press_s, press_e, press_w;
    logic       timeout, moved;

    assign dir     = {n, s, e, w};
    // A press is a single button rising out of an all-idle previous cycle.
    assign press   = (prev_q == 4'b0000) && $onehot(dir);
    assign press_n = press && dir[3];
    assign press_s = press && dir[2];
    assign press_e = press && dir[1];
    assign press_w = press && dir[0];
    assign timeout = (moves_q == MOVE_LIMIT);

    function automatic logic [6:0] room_of(input state_t st);
        case (st)
            S0:      room_of = 7'b0000001;
            S1:      room_of = 7'b0000010;
            S2:      room_of = 7'b0000100;
            S3:      room_of = 7'b0001000;
            S4:      room_of = 7'b0010000;
            WIN:     room_of = 7'b0100000;
            default: room_of = 7'b1000000;
        endcase
    endfunction

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        sword_d = sword_q;
        lives_d = lives_q;
        moves_d = moves_q;
        case (state_q)
            S0: if (timeout) state_d = OVER;
                else if (press_e) state_d = S1;
            S1: if (timeout) state_d = OVER;
                else if (press_s) state_d = S2;
                else if (press_w) state_d = S0;
            S2: if (timeout) state_d = OVER;
                else if (press_n) state_d = S1;
                else if (press_w) state_d = S3;
                else if (press_e) state_d = S4;
            S3: if (timeout) state_d = OVER;
                else if (press_e) state_d = S2;
            S4: begin
                if (sword_q) begin
                    state_d = WIN;
                end else begin
                    state_d = DEAD;
                    lives_d = lives_q - 1'b1;
                end
            end
            DEAD: begin
                if (lives_q != '0) begin
                    state_d = S0;
                    if (KEEP_SWORD == 0) sword_d = 1'b0;
                end else begin
                    state_d = OVER;
                end
            end
            default: ;
        endcase

        // Every room exit changes state, so a state change out of S0-S3 that is
        // not the timeout is exactly one accepted move.
        moved = (state_q inside {S0, S1, S2, S3}) && !timeout && (state_d != state_q);
        if (moved && moves_q != MOVE_LIMIT) moves_d = moves_q + 1'b1;
        if (moved && state_d == S3) sword_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S0;
            sword_q <= 1'b0;
            lives_q <= LIVES_INIT;
            moves_q <= '0;
            prev_q  <= 4'b0000;
            room_q  <= 7'b0000001;
            die_q   <= 1'b0;
            win_q   <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q <= state_d;
            sword_q <= sword_d;
            lives_q <= lives_d;
            moves_q <= moves_d;
            prev_q  <= dir;
            room_q  <= room_of(state_d);
            die_q   <= (state_d == DEAD) || (state_d == OVER);
            win_q   <= (state_d == WIN);
            over_q  <= (state_d == OVER);
        end
    end

    assign room      = room_q;
    assign sword     = sword_q;
    assign lives     = lives_q;
    assign moves     = moves_q;
    assign die       = die_q;
    assign win       = win_q;
    assign game_over = over_q;

    a_room_onehot: assert property (@(posedge clk) disable iff (reset) $onehot(room_q));
    a_win_die_excl: assert property (@(posedge clk) disable iff (reset) !(win_q && die_q));

endmodule

// File: tb/tb_adventure_game_ctrl.sv
// Bench for adventure_game_ctrl: four configurations share the buttons, each
// tracked by a room-map model and checked every cycle, plus literal spot checks.
module tb_adventure_game_ctrl;

    localparam int N = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic n = 1'b0, s = 1'b0, e = 1'b0, w = 1'b0;

    logic [6:0] room  [N];
    logic       sword [N];
    logic [1:0] lives [N];
    logic [7:0] moves [N];
    logic       die   [N];
    logic       win   [N];
    logic       govr  [N];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // 0: defaults; 1: single life; 2: move limit 4; 3: keep sword, large limit
    adventure_game_ctrl #(.LIVES(3), .LIFE_W(2), .MOVE_W(8), .MAX_MOVES(20), .KEEP_SWORD(0)) u_dut0 (
        .clk(clk), .reset(reset), .n(n), .s(s), .e(e), .w(w),
        .room(room[0]), .sword(sword[0]), .lives(lives[0]), .moves(moves[0]),
        .die(die[0]), .win(win[0]), .game_over(govr[0]));
    adventure_game_ctrl #(.LIVES(1), .LIFE_W(2), .MOVE_W(8), .MAX_MOVES(20), .KEEP_SWORD(0)) u_dut1 (
        .clk(clk), .reset(reset), .n(n), .s(s), .e(e), .w(w),
        .room(room[1]), .sword(sword[1]), .lives(lives[1]), .moves(moves[1]),
        .die(die[1]), .win(win[1]), .game_over(govr[1]));
    adventure_game_ctrl #(.LIVES(3), .LIFE_W(2), .MOVE_W(8), .MAX_MOVES(4), .KEEP_SWORD(0)) u_dut2 (
        .clk(clk), .reset(reset), .n(n), .s(s), .e(e), .w(w),
        .room(room[2]), .sword(sword[2]), .lives(lives[2]), .moves(moves[2]),
        .die(die[2]), .win(win[2]), .game_over(govr[2]));
    adventure_game_ctrl #(.LIVES(3), .LIFE_W(2), .MOVE_W(8), .MAX_MOVES(200), .KEEP_SWORD(1)) u_dut3 (
        .clk(clk), .reset(reset), .n(n), .s(s), .e(e), .w(w),
        .room(room[3]), .sword(sword[3]), .lives(lives[3]), .moves(moves[3]),
        .die(die[3]), .win(win[3]), .game_over(govr[3]));

    function automatic int cfg_lives(input int i);
        return (i == 1) ? 1 : 3;
    endfunction
    function automatic int cfg_max(input int i);
        return (i == 2) ? 4 : (i == 3) ? 200 : 20;
    endfunction
    function automatic int cfg_keep(input int i);
        return (i == 3) ? 1 : 0;
    endfunction

    // Location 0-4 = rooms, 5 = vault (won), 6 = graveyard (dead, or over when flagged).
    typedef struct {
        int loc;
        bit over;
        bit sword;
        int lives;
        int moves;
    } mstate_t;

    mstate_t    m [N];
    logic [3:0] prev_m;

    // Room map; direction index 0=n 1=s 2=e 3=w; -1 = wall.
    function automatic int exit_of(input int loc, input int d);
        int t [4][4];
        t[0] = '{-1, -1, 1, -1};
        t[1] = '{-1, 2, -1, 0};
        t[2] = '{1, -1, 4, 3};
        t[3] = '{-1, -1, 2, -1};
        return t[loc][d];
    endfunction

    function automatic mstate_t step(input mstate_t c, input int i, input int pd);
        mstate_t r = c;
        if (c.over || c.loc == 5) return r;
        if (c.loc == 6) begin
            if (c.lives > 0) begin
                r.loc = 0;
                if (cfg_keep(i) == 0) r.sword = 1'b0;
            end else begin
                r.over = 1'b1;
            end
        end else if (c.loc == 4) begin
            if (c.sword) r.loc = 5;
            else begin
                r.loc   = 6;
                r.lives = c.lives - 1;
            end
        end else if (c.moves == cfg_max(i)) begin
            r.loc  = 6;
            r.over = 1'b1;
        end else if (pd >= 0 && exit_of(c.loc, pd) >= 0) begin
            r.loc   = exit_of(c.loc, pd);
            r.moves = c.moves + 1;
            if (r.loc == 3) r.sword = 1'b1;
        end
        return r;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) m[i] <= '{0, 1'b0, 1'b0, cfg_lives(i), 0};
            prev_m <= 4'b0000;
        end else begin
            int pd;
            logic [3:0] dv;
            dv = {n, s, e, w};
            pd = -1;
            if (prev_m == 4'b0000 && $countones(dv) == 1)
                for (int k = 0; k < 4; k++) if (dv[3-k]) pd = k;
            for (int i = 0; i < N; i++) m[i] <= step(m[i], i, pd);
            prev_m <= dv;
        end
    end

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d at %0t: got %0h, expected %0h", name, idx, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            check("room",      i, 32'(room[i]),  32'(1 << m[i].loc));
            check("sword",     i, 32'(sword[i]), 32'(m[i].sword));
            check("lives",     i, 32'(lives[i]), 32'(m[i].lives));
            check("moves",     i, 32'(moves[i]), 32'(m[i].moves));
            check("die",       i, 32'(die[i]),   32'(m[i].loc == 6));
            check("win",       i, 32'(win[i]),   32'(m[i].loc == 5));
            check("game_over", i, 32'(govr[i]),  32'(m[i].over));
        end
    end

    task automatic do_reset();
        {n, s, e, w} = 4'b0000;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // One-cycle pulse; returns at the falling edge after the accepting edge.
    task automatic press(input logic [3:0] d);
        @(negedge clk);
        {n, s, e, w} = d;
        @(negedge clk);
        {n, s, e, w} = 4'b0000;
    endtask

    localparam logic [3:0] BN = 4'b1000, BS = 4'b0100, BE = 4'b0010, BW = 4'b0001;

    initial begin
        repeat (2) @(negedge clk);
        check("rst_room", 0, 32'(room[0]), 32'h01);
        check("rst_lives", 0, 32'(lives[0]), 32'd3);
        do_reset();

        // Win path
        press(BE); press(BS); press(BW);
        check("s3_sword", 0, 32'(sword[0]), 32'd1);
        press(BE); press(BE);
        check("den", 0, 32'(room[0]), 32'h10);
        @(negedge clk);
        check("win_flag", 0, 32'(win[0]), 32'd1);
        check("win_room", 0, 32'(room[0]), 32'h20);
        check("win_moves", 0, 32'(moves[0]), 32'd5);

        // Death, respawn, and single-life game over
        do_reset();
        press(BE); press(BS); press(BE);
        check("den_nodie", 0, 32'(die[0]), 32'd0);
        @(negedge clk);
        check("dead_die", 0, 32'(die[0]), 32'd1);
        check("dead_lives", 0, 32'(lives[0]), 32'd2);
        check("dead_room", 0, 32'(room[0]), 32'h40);
        check("one_dead_go", 1, 32'(govr[1]), 32'd0);
        @(negedge clk);
        check("respawn_room", 0, 32'(room[0]), 32'h01);
        check("respawn_die", 0, 32'(die[0]), 32'd0);
        check("respawn_moves", 0, 32'(moves[0]), 32'd3);
        check("over_go", 1, 32'(govr[1]), 32'd1);
        check("over_lives", 1, 32'(lives[1]), 32'd0);
        press(BE); press(BS);
        check("over_frozen", 1, 32'(room[1]), 32'h40);
        check("over_moves", 1, 32'(moves[1]), 32'd3);

        // Held button, chord, and wall
        do_reset();
        @(negedge clk);
        e = 1'b1;
        repeat (10) @(negedge clk);
        e = 1'b0;
        @(negedge clk);
        check("hold_moves", 0, 32'(moves[0]), 32'd1);
        check("hold_room", 0, 32'(room[0]), 32'h02);
        press(BN | BE);
        check("chord_moves", 0, 32'(moves[0]), 32'd1);
        do_reset();
        press(BN);
        check("wall_room", 0, 32'(room[0]), 32'h01);
        check("wall_moves", 0, 32'(moves[0]), 32'd0);

        // Timeout with limit 4
        do_reset();
        press(BE); press(BW); press(BE); press(BW);
        check("to_moves", 2, 32'(moves[2]), 32'd4);
        check("to_room", 2, 32'(room[2]), 32'h01);
        check("to_pre_go", 2, 32'(govr[2]), 32'd0);
        @(negedge clk);
        check("to_go", 2, 32'(govr[2]), 32'd1);
        check("to_lives", 2, 32'(lives[2]), 32'd3);

        // Keep-sword configuration, then asynchronous reset out of WIN
        do_reset();
        press(BE); press(BS); press(BW); press(BE); press(BN); press(BW);
        check("keep_room", 3, 32'(room[3]), 32'h01);
        check("keep_moves", 3, 32'(moves[3]), 32'd6);
        repeat (20) @(negedge clk);
        check("keep_sword", 3, 32'(sword[3]), 32'd1);
        press(BE); press(BS); press(BE);
        @(negedge clk);
        check("keep_win", 3, 32'(win[3]), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("arst_room", 3, 32'(room[3]), 32'h01);
        check("arst_win", 3, 32'(win[3]), 32'd0);
        check("arst_sword", 3, 32'(sword[3]), 32'd0);
        check("arst_moves", 3, 32'(moves[3]), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
